ps2_host_tx: RTL
================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 12000, clk cycles the host holds PS/2 clock low before the start bit (120 us at 100 MHz).
REQ-002 SHALL have parameter START_CYCLES, default 16, clk cycles data and clock are both held low before the clock is released.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2000000, watchdog limit in clk cycles (20 ms at 100 MHz); used only under REQ-027.
REQ-004 SHALL have port clk, input, 1, system clock (100 MHz).
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port ps2_clk_in, input, 1, raw PS/2 clock pin level.
REQ-007 SHALL have port ps2_data_in, input, 1, raw PS/2 data pin level.
REQ-008 SHALL have port ps2_clk_oe, output, 1, 1 = drive PS/2 clock low; 0 = release (open-drain).
REQ-009 SHALL have port ps2_data_oe, output, 1, 1 = drive PS/2 data low; 0 = release (open-drain).
REQ-010 SHALL have port tx_data, input, 8, command byte to send (e.g. 8'hF4, 8'hFF).
REQ-011 SHALL have port tx_valid, input, 1, request to send tx_data.
REQ-012 SHALL have port tx_ready, output, 1, high only in IDLE.
REQ-013 SHALL have port tx_done, output, 1, one-cycle pulse: byte acknowledged by the device.
REQ-014 SHALL have port tx_err, output, 1, one-cycle pulse: NACK or timeout.

Function
REQ-015 SHALL synchronise ps2_clk_in and ps2_data_in through two flip-flops each; a falling edge is sync-prev=1 and sync-current=0.
REQ-016 SHALL implement states IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE.
REQ-017 SHALL, in IDLE, accept a byte when tx_valid && tx_ready: latch tx_data, compute odd parity (~^tx_data), and enter INHIBIT on the next cycle; tx_valid outside IDLE SHALL be ignored (no queueing).
REQ-018 SHALL, in INHIBIT, assert ps2_clk_oe=1 and ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then enter START.
REQ-019 SHALL, in START, assert ps2_clk_oe=1 and ps2_data_oe=1 (start bit) for START_CYCLES cycles, then release ps2_clk_oe and enter SHIFT with bit index 0.
REQ-020 SHALL, in SHIFT, on each detected clock falling edge, drive the next frame bit: data bits 0..7 LSB first, then parity, then stop (ps2_data_oe=0); ps2_data_oe = ~bit for each bit.
REQ-021 SHALL enter ACK after the edge that drives the stop bit, and SHALL sample synchronised data on the next falling edge: 0 = ACK, 1 = NACK.
REQ-022 SHALL, after ACK sampling, enter WAIT_IDLE with both lines released, and return to IDLE once synchronised clock and data are both 1.
REQ-023 SHALL pulse tx_done (ACK) or tx_err (NACK) for one cycle on the transition from WAIT_IDLE to IDLE; never both.
REQ-024 SHALL keep ps2_clk_oe=0 in every state except INHIBIT and START.

Reset
REQ-025 SHALL, while reset=1, force state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_err=0, and counters to 0; tx_ready SHALL be 1 from the first clk edge after reset deassertion.
REQ-026 SHALL, on reset mid-frame, release both PS/2 lines immediately (asynchronously) and emit no tx_done or tx_err pulse.

Configuration
REQ-027 SHALL, with PS2_TX_TIMEOUT_EN defined, run a watchdog in SHIFT, ACK and WAIT_IDLE that clears on state entry and on each falling edge; when it reaches TIMEOUT_CYCLES, both lines are released, tx_err pulses once, and the state returns to IDLE.
REQ-028 SHALL, without PS2_TX_TIMEOUT_EN, omit the watchdog logic entirely; the block waits indefinitely for device clock edges, and tx_err reports NACK only.

Verification
REQ-029 SHALL cover: tx_data=8'hF4, device model clocks 11 edges at 12.5 kHz and ACKs -> data-line bits 0,0,1,0,1,1,1,1, parity 0, stop 1; tx_done pulses once; tx_ready returns to 1.
REQ-030 SHALL cover: tx_data=8'hFF with the device holding data high at the ACK edge -> parity 1; tx_err pulses once; tx_done stays 0.
REQ-031 SHALL cover: tx_valid held high in IDLE -> ps2_clk_oe low for exactly 12000 cycles, then data low 16 cycles before clock release; a second tx_valid during SHIFT is ignored.
REQ-032 SHALL cover: reset asserted after the 4th data edge -> ps2_clk_oe=ps2_data_oe=0 in the same cycle; no tx_done or tx_err pulse; a new byte is accepted after reset.
REQ-033 SHALL cover: with PS2_TX_TIMEOUT_EN, the device stops clocking after 3 edges -> tx_err pulses 2000000 cycles after the last edge; without the macro, the block stays in SHIFT.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, bit shift on device clock, ACK check.
// Optional watchdog in SHIFT/ACK/WAIT_IDLE is compiled in when PS2_TX_TIMEOUT_EN is defined.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int START_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic [2:0] state_dbg
);

  // Handshake: a byte is taken on a clk edge where tx_valid && tx_ready; tx_ready is
  // high only in IDLE, and tx_valid seen in any other state is dropped, not queued.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  localparam int CNT_MAX_A = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int CNT_MAX   = (TIMEOUT_CYCLES > CNT_MAX_A) ? TIMEOUT_CYCLES : CNT_MAX_A;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       bit_idx, bit_idx_n;
  logic [9:0]       frame, frame_n;
  logic             nack, nack_n;
  logic             data_oe_q, data_oe_n;
  logic             done_n, err_n;
  logic             ready_en;
  logic [1:0]       clk_sync, data_sync;
  logic             clk_prev;
  logic             clk_fall;

  // Sync flops reset high so a line that idles high never looks like a falling edge.
  assign clk_fall    = clk_prev & ~clk_sync[1];
  assign ps2_clk_oe  = (state == INHIBIT) || (state == START);
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = (state == IDLE) && ready_en;
  assign state_dbg   = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      frame     <= '0;
      nack      <= 1'b0;
      data_oe_q <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
      ready_en  <= 1'b0;
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      frame     <= frame_n;
      nack      <= nack_n;
      data_oe_q <= data_oe_n;
      tx_done   <= done_n;
      tx_err    <= err_n;
      ready_en  <= 1'b1;
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= clk_sync[1];
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    frame_n   = frame;
    nack_n    = nack;
    data_oe_n = data_oe_q;
    done_n    = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        data_oe_n = 1'b0;
        if (tx_valid && tx_ready) begin
          // Frame bits in line order: data LSB first, odd parity, stop.
          frame_n = {1'b1, ~^tx_data, tx_data};
          cnt_n   = '0;
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt == INH_LAST) begin
          cnt_n     = '0;
          data_oe_n = 1'b1;
          state_n   = START;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      START: begin
        if (cnt == START_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = SHIFT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (clk_fall) begin
          data_oe_n = ~frame[bit_idx];
          bit_idx_n = bit_idx + 4'd1;
          if (bit_idx == 4'd9) state_n = ACK;
        end
      end
      ACK: begin
        if (clk_fall) begin
          nack_n  = data_sync[1];
          state_n = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        data_oe_n = 1'b0;
        if (clk_sync[1] && data_sync[1]) begin
          state_n = IDLE;
          done_n  = ~nack;
          err_n   = nack;
        end
      end
      default: begin
        state_n   = IDLE;
        data_oe_n = 1'b0;
      end
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog shares cnt: it restarts on every device clock edge and on state change.
    if (state == SHIFT || state == ACK || state == WAIT_IDLE) begin
      if (clk_fall || (state_n != state)) begin
        cnt_n = '0;
      end else if (cnt == TMO_LAST) begin
        cnt_n     = '0;
        state_n   = IDLE;
        data_oe_n = 1'b0;
        done_n    = 1'b0;
        err_n     = 1'b1;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end
`endif
  end

endmodule
